// File: rtl/bus_transfer_sequencer_if.sv
// Handshake and bus-control bundle between the operation requester and the
// transfer sequencer.
interface bus_transfer_sequencer_if;
  logic        start;
  logic        op_mul;
  logic        use_imm;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        alu_done;
  logic [23:0] bus_sel;
  logic        Yin;
  logic        Zin;
  logic        alu_go;
  logic [15:0] reg_in;
  logic        HIin;
  logic        LOin;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, op_mul, use_imm, ra, rb, rc, alu_done,
    input  bus_sel, Yin, Zin, alu_go, reg_in, HIin, LOin, busy, done, err
  );

  modport slave (
    input  start, op_mul, use_imm, ra, rb, rc, alu_done,
    output bus_sel, Yin, Zin, alu_go, reg_in, HIin, LOin, busy, done, err
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Micro-step sequencer for the shared datapath bus: walks one ALU or MUL/DIV
// register transfer through its bus cycles with at most one bus source active.
module bus_transfer_sequencer #(
  parameter int unsigned WAIT_MAX = 64
) (
  input logic                    clock,
  input logic                    clear,
  bus_transfer_sequencer_if.slave bus
);
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEL_W   = 24;
  localparam int unsigned REG_W   = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SEL_ZHI = 18;
  localparam int unsigned SEL_ZLO = 19;
  localparam int unsigned SEL_C   = 23;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [3:0] {
    IDLE, T1, T2, WAIT, ZLD, TLO, THI, TWR, DONE
  } state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   waitCnt, waitCntNext;
  logic               opMul, opMulNext;
  logic               useImm, useImmNext;
  logic [IDX_W-1:0]   dstReg, dstRegNext;
  logic [IDX_W-1:0]   srcB, srcBNext;
  logic [IDX_W-1:0]   srcC, srcCNext;

  logic [SEL_W-1:0]   busSel, busSelNext;
  logic [REG_W-1:0]   regIn, regInNext;
  logic               yIn, yInNext;
  logic               zIn, zInNext;
  logic               aluGo, aluGoNext;
  logic               hiIn, hiInNext;
  logic               loIn, loInNext;
  logic               busyQ, busyNext;
  logic               doneQ, doneNext;
  logic               errQ, errNext;

  // State, counter, latched operation fields and registered control outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      waitCnt <= '0;
      opMul   <= 1'b0;
      useImm  <= 1'b0;
      dstReg  <= '0;
      srcB    <= '0;
      srcC    <= '0;
      busSel  <= '0;
      regIn   <= '0;
      yIn     <= 1'b0;
      zIn     <= 1'b0;
      aluGo   <= 1'b0;
      hiIn    <= 1'b0;
      loIn    <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      opMul   <= opMulNext;
      useImm  <= useImmNext;
      dstReg  <= dstRegNext;
      srcB    <= srcBNext;
      srcC    <= srcCNext;
      busSel  <= busSelNext;
      regIn   <= regInNext;
      yIn     <= yInNext;
      zIn     <= zInNext;
      aluGo   <= aluGoNext;
      hiIn    <= hiInNext;
      loIn    <= loInNext;
      busyQ   <= busyNext;
      doneQ   <= doneNext;
      errQ    <= errNext;
    end
  end

  // Next state, then outputs decoded from the state being entered so the
  // registered outputs line up with that state's cycle.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    opMulNext   = opMul;
    useImmNext  = useImm;
    dstRegNext  = dstReg;
    srcBNext    = srcB;
    srcCNext    = srcC;
    busSelNext  = '0;
    regInNext   = '0;
    yInNext     = 1'b0;
    zInNext     = 1'b0;
    aluGoNext   = 1'b0;
    hiInNext    = 1'b0;
    loInNext    = 1'b0;
    busyNext    = 1'b0;
    doneNext    = 1'b0;
    errNext     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext  = T1;
          opMulNext  = bus.op_mul;
          useImmNext = bus.use_imm;
          dstRegNext = bus.ra;
          srcBNext   = bus.rb;
          srcCNext   = bus.rc;
        end
      end
      T1: stateNext = T2;
      T2: begin
        if (opMul) begin
          stateNext   = WAIT;
          waitCntNext = '0;
        end else begin
          stateNext = TWR;
        end
      end
      // alu_done on the final counted cycle still wins over the timeout.
      WAIT: begin
        if (bus.alu_done) begin
          stateNext = ZLD;
        end else if (waitCnt == WAIT_LAST) begin
          stateNext = DONE;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end
      ZLD:     stateNext = TLO;
      TLO:     stateNext = THI;
      THI:     stateNext = DONE;
      TWR:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    busyNext = (stateNext != IDLE);
    unique case (stateNext)
      T1: begin
        busSelNext = SEL_W'(1) << srcBNext;
        yInNext    = 1'b1;
      end
      T2: begin
        if (opMulNext) begin
          busSelNext = SEL_W'(1) << srcCNext;
          aluGoNext  = 1'b1;
        end else begin
          busSelNext = useImmNext ? (SEL_W'(1) << SEL_C) : (SEL_W'(1) << srcCNext);
          zInNext    = 1'b1;
        end
      end
      ZLD: zInNext = 1'b1;
      TLO: begin
        busSelNext = SEL_W'(1) << SEL_ZLO;
        loInNext   = 1'b1;
      end
      THI: begin
        busSelNext = SEL_W'(1) << SEL_ZHI;
        hiInNext   = 1'b1;
      end
      TWR: begin
        busSelNext = SEL_W'(1) << SEL_ZLO;
        regInNext  = REG_W'(1) << dstRegNext;
      end
      // The only path from WAIT straight to DONE is the timeout abort.
      DONE: begin
        doneNext = 1'b1;
        errNext  = (state == WAIT);
      end
      default: ;
    endcase
  end

  assign bus.bus_sel = busSel;
  assign bus.reg_in  = regIn;
  assign bus.Yin     = yIn;
  assign bus.Zin     = zIn;
  assign bus.alu_go  = aluGo;
  assign bus.HIin    = hiIn;
  assign bus.LOin    = loIn;
  assign bus.busy    = busyQ;
  assign bus.done    = doneQ;
  assign bus.err     = errQ;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: random operations compared cycle by cycle
// against an operation-level model of the expected bus schedule.
module tb_bus_transfer_sequencer;
  localparam int WAIT_MAX = 6;

  typedef struct packed {
    logic [23:0] bs;
    logic [15:0] ri;
    logic        yin;
    logic        zin;
    logic        go;
    logic        hi;
    logic        lo;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  obs_t expQ[$];
  obs_t obsQ[$];

  bus_transfer_sequencer_if busIf();

  bus_transfer_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (busIf)
  );

  always #5 clock = ~clock;

  function automatic obs_t sampleObs();
    obs_t o;
    o.bs   = busIf.bus_sel;
    o.ri   = busIf.reg_in;
    o.yin  = busIf.Yin;
    o.zin  = busIf.Zin;
    o.go   = busIf.alu_go;
    o.hi   = busIf.HIin;
    o.lo   = busIf.LOin;
    o.busy = busIf.busy;
    o.done = busIf.done;
    o.err  = busIf.err;
    return o;
  endfunction

  // One busy cycle driving bus source sel (-1 none) and writing register wr (-1 none).
  function automatic obs_t step(int sel, int wr);
    obs_t e;
    e = '0;
    e.busy = 1'b1;
    if (sel >= 0) e.bs = 24'(1) << sel;
    if (wr >= 0)  e.ri = 16'(1) << wr;
    return e;
  endfunction

  function automatic int waitLen(int n);
    return (n >= 1 && n <= WAIT_MAX) ? n : WAIT_MAX;
  endfunction

  // Expected schedule of one operation; n = WAIT cycle where alu_done rises (else timeout).
  task automatic buildModel(input logic opMul, input logic useImm,
                            input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input int n);
    obs_t e;
    expQ.delete();
    e = step(int'(rb), -1); e.yin = 1'b1; expQ.push_back(e);
    if (!opMul) begin
      e = step(useImm ? 23 : int'(rc), -1); e.zin = 1'b1; expQ.push_back(e);
      e = step(19, int'(ra)); expQ.push_back(e);
      e = step(-1, -1); e.done = 1'b1; expQ.push_back(e);
    end else begin
      e = step(int'(rc), -1); e.go = 1'b1; expQ.push_back(e);
      repeat (waitLen(n)) expQ.push_back(step(-1, -1));
      if (n >= 1 && n <= WAIT_MAX) begin
        e = step(-1, -1); e.zin = 1'b1; expQ.push_back(e);
        e = step(19, -1); e.lo = 1'b1; expQ.push_back(e);
        e = step(18, -1); e.hi = 1'b1; expQ.push_back(e);
        e = step(-1, -1); e.done = 1'b1; expQ.push_back(e);
      end else begin
        e = step(-1, -1); e.done = 1'b1; e.err = 1'b1; expQ.push_back(e);
      end
    end
    expQ.push_back(obs_t'('0));
  endtask

  // Starts from an IDLE cycle, records every cycle of the op plus the IDLE after it.
  task automatic runOp(input logic opMul, input logic useImm,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input int n, input bit hold);
    int waits;
    buildModel(opMul, useImm, ra, rb, rc, n);
    waits = waitLen(n);
    obsQ.delete();
    busIf.start    = 1'b1;
    busIf.op_mul   = opMul;
    busIf.use_imm  = useImm;
    busIf.ra       = ra;
    busIf.rb       = rb;
    busIf.rc       = rc;
    busIf.alu_done = 1'($urandom);
    @(posedge clock); #1;
    for (int c = 1; c <= expQ.size(); c++) begin
      obsQ.push_back(sampleObs());
      if (c == expQ.size()) break;
      busIf.start   = hold ? 1'b1 : 1'($urandom);
      busIf.op_mul  = 1'($urandom);
      busIf.use_imm = 1'($urandom);
      {busIf.ra, busIf.rb, busIf.rc} = 12'($urandom);
      if (opMul && c >= 3 && c <= 2 + waits) busIf.alu_done = (c == 2 + n);
      else busIf.alu_done = 1'($urandom);
      @(posedge clock); #1;
    end
    if (!hold) busIf.start = 1'b0;
  endtask

  task automatic test_reset();
    busIf.start = 1'b0; busIf.op_mul = 1'b0; busIf.use_imm = 1'b0;
    busIf.ra = '0; busIf.rb = '0; busIf.rc = '0; busIf.alu_done = 1'b0;
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (sampleObs() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL reset_held: got %h required %h", sampleObs(), obs_t'('0));
    end
    @(negedge clock) clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busIf.alu_done = 1'($urandom);
      @(posedge clock); #1;
      vectors++;
      if (sampleObs() !== obs_t'('0)) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: got %h required %h", i, sampleObs(), obs_t'('0));
      end
    end
  endtask

  task automatic test_alu_reg();
    runOp(1'b0, 1'b0, 4'd7, 4'd3, 4'd5, 0, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obsQ[i] !== expQ[i] || $countones(obsQ[i].bs) > 1) begin
        miscompares++;
        $display("FAIL alu_reg cycle %0d: got %h required %h", i + 1, obsQ[i], expQ[i]);
      end
    end
    vectors++;
    if (obsQ[0].bs !== 24'h000008 || obsQ[1].bs !== 24'h000020 ||
        obsQ[2].bs !== 24'h080000 || obsQ[2].ri !== 16'h0080 || obsQ[3].done !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_reg_literal: got bs %h %h %h ri %h done %b required 000008 000020 080000 0080 1",
               obsQ[0].bs, obsQ[1].bs, obsQ[2].bs, obsQ[2].ri, obsQ[3].done);
    end
  endtask

  task automatic test_alu_imm();
    runOp(1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 0, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obsQ[i] !== expQ[i] || obsQ[i].bs[9] !== 1'b0 || $countones(obsQ[i].bs) > 1) begin
        miscompares++;
        $display("FAIL alu_imm cycle %0d: got %h required %h", i + 1, obsQ[i], expQ[i]);
      end
    end
    vectors++;
    if (obsQ[1].bs !== 24'h800000) begin
      miscompares++;
      $display("FAIL alu_imm_c: got %h required 800000", obsQ[1].bs);
    end
  endtask

  task automatic test_mul();
    int goCount;
    runOp(1'b1, 1'b1, 4'd4, 4'd1, 4'd2, 5, 1'b0);
    goCount = 0;
    for (int i = 0; i < expQ.size(); i++) begin
      goCount += int'(obsQ[i].go);
      vectors++;
      if (obsQ[i] !== expQ[i] || $countones(obsQ[i].bs) > 1) begin
        miscompares++;
        $display("FAIL mul cycle %0d: got %h required %h", i + 1, obsQ[i], expQ[i]);
      end
    end
    vectors++;
    if (goCount != 1 || obsQ[1].go !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_go_pulse: got count %0d cycle2 %b required 1 1", goCount, obsQ[1].go);
    end
  endtask

  task automatic test_timeout();
    runOp(1'b1, 1'b0, 4'd6, 4'd8, 4'd15, 0, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obsQ[i] !== expQ[i] || (i >= 2 && (obsQ[i].hi || obsQ[i].lo || obsQ[i].zin))) begin
        miscompares++;
        $display("FAIL timeout cycle %0d: got %h required %h", i + 1, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_wait_edges();
    int edges[3];
    edges = '{1, WAIT_MAX, WAIT_MAX + 1};
    foreach (edges[k]) begin
      runOp(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), edges[k], 1'b0);
      for (int i = 0; i < expQ.size(); i++) begin
        vectors++;
        if (obsQ[i] !== expQ[i] || $countones(obsQ[i].bs) > 1) begin
          miscompares++;
          $display("FAIL wait_edge n=%0d cycle %0d: got %h required %h", edges[k], i + 1, obsQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lastLen;
    lastLen = 0;
    for (int op = 0; op < 4; op++) begin
      runOp(1'(op), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            $urandom_range(1, WAIT_MAX), 1'b1);
      for (int i = 0; i < expQ.size(); i++) begin
        vectors++;
        if (obsQ[i] !== expQ[i] || $countones(obsQ[i].bs) > 1) begin
          miscompares++;
          $display("FAIL back_to_back op %0d cycle %0d: got %h required %h", op, i + 1, obsQ[i], expQ[i]);
        end
      end
      lastLen = expQ.size();
    end
    busIf.start = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (lastLen == 0 || sampleObs() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL back_to_back_drain: got %h required %h", sampleObs(), obs_t'('0));
    end
  endtask

  task automatic test_random();
    int n;
    for (int op = 0; op < 40; op++) begin
      n = $urandom_range(0, WAIT_MAX + 2);
      runOp(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), n, 1'($urandom));
      for (int i = 0; i < expQ.size(); i++) begin
        vectors++;
        if (obsQ[i] !== expQ[i] || $countones(obsQ[i].bs) > 1) begin
          miscompares++;
          $display("FAIL random op %0d cycle %0d: got %h required %h", op, i + 1, obsQ[i], expQ[i]);
        end
      end
    end
    busIf.start = 1'b0;
  endtask

  task automatic test_reset_midop();
    obs_t e;
    busIf.start = 1'b1; busIf.op_mul = 1'b1; busIf.use_imm = 1'b0;
    busIf.ra = 4'd3; busIf.rb = 4'd1; busIf.rc = 4'd2; busIf.alu_done = 1'b0;
    @(posedge clock); #1;
    busIf.start = 1'b0;
    @(posedge clock); #1;
    e = step(2, -1); e.go = 1'b1;
    vectors++;
    if (sampleObs() !== e) begin
      miscompares++;
      $display("FAIL midop_t2: got %h required %h", sampleObs(), e);
    end
    #2 clear = 1'b1;
    #1;
    vectors++;
    if (sampleObs() !== obs_t'('0)) begin
      miscompares++;
      $display("FAIL midop_async_clear: got %h required %h", sampleObs(), obs_t'('0));
    end
    @(posedge clock);
    @(negedge clock) clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      busIf.alu_done = 1'($urandom);
      @(posedge clock); #1;
      vectors++;
      if (sampleObs() !== obs_t'('0)) begin
        miscompares++;
        $display("FAIL midop_after_clear cycle %0d: got %h required %h", i, sampleObs(), obs_t'('0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_reg();
    test_alu_imm();
    test_mul();
    test_timeout();
    test_wait_edges();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
